rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single registered-read instruction ROM port between two requesters.
- Requester IF is instruction fetch. Requester MEM is a load from code space, e.g. a constant table or a loader readback.
- Owns the ROM chip-enable and address, and sequences each access through a 3-state FSM.
- Returns the read word to the granted requester and raises a pipeline stall request to the stall controller while any request is outstanding.

Parameters:
- ADDR_W, 32, width of the ROM address bus (same as the codebase ROM address bus).
- DATA_W, 32, width of the instruction/data word (same as the codebase instruction bus).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (rst==0 resets).
- if_req  input  1  fetch request, level; held until if_valid.
- if_addr  input  ADDR_W  fetch byte address; stable while if_req=1.
- if_rdata  output  DATA_W  fetched word; meaningful when if_valid=1.
- if_valid  output  1  one-cycle completion pulse for IF.
- mem_req  input  1  MEM-side read request, level; held until mem_valid.
- mem_addr  input  ADDR_W  MEM-side byte address; stable while mem_req=1.
- mem_rdata  output  DATA_W  read word for MEM.
- mem_valid  output  1  one-cycle completion pulse for MEM.
- rom_ce  output  1  ROM chip enable, registered.
- rom_addr  output  ADDR_W  ROM address, registered.
- rom_inst  input  DATA_W  ROM read data, registered inside the ROM, valid the cycle after ce is sampled.
- rom_ack  input  1  ROM data-ready; 0 inserts wait states.
- stall_req  output  1  to pipeline stall controller.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - rom_ce=0, rom_addr=0.
  - if_rdata=mem_rdata=0 (zero word), if_valid=mem_valid=0.
  - The owner register clears to IF; the last-grant register clears to MEM.
- Reset mid-access abandons the access; no valid pulse is produced afterwards. Requesters must re-issue.
- FSM states: IDLE, ISSUE, DATA.
- IDLE:
  - If no request, stay in IDLE with rom_ce=0.
  - Otherwise pick an owner (priority rule below), register rom_addr=owner addr and rom_ce=1, and go to ISSUE.
- ISSUE: the ROM samples ce/addr at this edge. Go to DATA.
  - rom_ce stays 1 through DATA only while waiting (see DATA).
- DATA:
  - If rom_ack=1: latch rom_inst into the owner's rdata, pulse the owner's valid for exactly the next cycle, set rom_ce=0, go to IDLE.
  - If rom_ack=0: hold rom_ce=1 and rom_addr, stay in DATA.
- Latency: request first seen at edge E0 yields valid high in the cycle after E2 (3 cycles, zero wait states). Maximum throughput is one access per 3 cycles.
- Back-to-back: during its valid cycle a requester may present a new addr with req held high. IDLE samples this at the next edge as a new request. The arbiter never uses the owner's req during DATA.
- rdata holds its last value between accesses; the non-owner's rdata is never modified.
- Priority (default): when both requests are asserted in IDLE, MEM wins (older instruction in the pipeline). A single requester is always granted.
- stall_req = (if_req & ~if_valid) | (mem_req & ~mem_valid), combinational.
- Addresses pass through unmodified; alignment is the requester's responsibility.
- Requests arriving in ISSUE/DATA wait; they are not lost because req is level-held.

Optional Feature:
- Macro ROM_ARB_RR_EN.
- Defined: round-robin arbitration. When both request in IDLE, grant the one not granted last (last-grant register updated on every grant). Neither requester starves.
- Undefined: fixed MEM-over-IF priority; the last-grant register is absent.

Decomposition:
- Shared defines/package entries: state encodings (IDLE/ISSUE/DATA), owner encodings (OWNER_IF, OWNER_MEM), and the ROM address/instruction bus width constants already used by the ROM driver.
- One natural sub-module, rom_arb_pick: combinational 2-way pick taking both reqs and the last-grant bit, producing the owner. Its RR logic sits under ROM_ARB_RR_EN.

Test Plan:
- Single IF read:
  - Stimulus: if_req=1, if_addr=0x00000004, ROM word 0x34011100, rom_ack=1.
  - Response: rom_ce=1 with rom_addr=0x4 after E0; if_valid=1 with if_rdata=0x34011100 in the cycle after E2. stall_req=1 from the request cycle until the valid cycle, 0 during valid.
- Simultaneous requests:
  - Stimulus: if_req and mem_req both rise, addrs 0x0 and 0x8.
  - Response (fixed priority): mem_valid first, if_valid 3 cycles later.
  - Response (ROM_ARB_RR_EN, last grant MEM after reset): IF served first, then MEM.
- Wait states:
  - Stimulus: rom_ack=0 for 2 cycles in DATA.
  - Response: rom_ce and rom_addr held constant, valid delayed by exactly 2 cycles, correct data.
- Back-to-back IF:
  - Stimulus: IF keeps req high and changes addr to 0x8 in its valid cycle.
  - Response: second access is issued; valid pulses 3 cycles apart; mem_rdata unchanged.
- Reset mid-access:
  - Stimulus: rst=0 pulse while in DATA.
  - Response: immediately rom_ce=0, valids 0, rdatas 0, state IDLE; no valid pulse after release until a new request.
- Starvation under RR:
  - Stimulus: both reqs held high continuously for 12 cycles with ROM_ARB_RR_EN.
  - Response: grants alternate MEM, IF, MEM, IF.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared encodings and bus widths for the instruction ROM port arbiter.
package rom_arbiter_pkg;

  localparam int ROM_ADDR_W = 32;
  localparam int ROM_INST_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational 2-way owner pick; ROM_ARB_RR_EN switches fixed MEM priority to round-robin.
module rom_arb_pick
  import rom_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   mem_req,
`ifdef ROM_ARB_RR_EN
  input  owner_t last_grant,
`endif
  output owner_t owner
);

  always_comb begin
    owner = OWNER_IF;
`ifdef ROM_ARB_RR_EN
    // On contention, favour whoever was not granted last so neither side starves
    if (if_req && mem_req)
      owner = (last_grant == OWNER_MEM) ? OWNER_IF : OWNER_MEM;
    else if (mem_req)
      owner = OWNER_MEM;
    else if (if_req)
      owner = OWNER_IF;
`else
    if (mem_req)
      owner = OWNER_MEM;
    else if (if_req)
      owner = OWNER_IF;
`endif
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the registered-read instruction ROM between fetch (IF) and code-space loads (MEM).
// Optional macro ROM_ARB_RR_EN enables round-robin arbitration instead of MEM priority.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  input  logic              rom_ack,
  output logic              stall_req
);

  arb_state_t state;
  owner_t     owner;
  owner_t     pick;
`ifdef ROM_ARB_RR_EN
  owner_t     last_grant;
`endif

  rom_arb_pick u_pick (
    .if_req     (if_req),
    .mem_req    (mem_req),
`ifdef ROM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .owner      (pick)
  );

  assign stall_req = (if_req & ~if_valid) | (mem_req & ~mem_valid);

  // ce stays high from the grant until the ack edge, so wait states see a stable address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWNER_IF;
      rom_ce     <= 1'b0;
      rom_addr   <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_valid   <= 1'b0;
      mem_valid  <= 1'b0;
`ifdef ROM_ARB_RR_EN
      last_grant <= OWNER_MEM;
`endif
    end else begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || mem_req) begin
            owner    <= pick;
            rom_addr <= (pick == OWNER_MEM) ? mem_addr : if_addr;
            rom_ce   <= 1'b1;
            state    <= ISSUE;
`ifdef ROM_ARB_RR_EN
            last_grant <= pick;
`endif
          end else begin
            rom_ce <= 1'b0;
          end
        end
        ISSUE: state <= DATA;
        DATA: begin
          if (rom_ack) begin
            if (owner == OWNER_MEM) begin
              mem_rdata <= rom_inst;
              mem_valid <= 1'b1;
            end else begin
              if_rdata <= rom_inst;
              if_valid <= 1'b1;
            end
            rom_ce <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst = '0;
  logic        rom_ack = 1'b1;
  logic        stall_req;

  int tests = 0;
  int failed = 0;

  rom_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst), .rom_ack(rom_ack),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [31:0] a);
    if (a == 32'h4) return 32'h3401_1100;
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  // Registered-read ROM: data for the sampled address appears after the edge
  always @(posedge clk) if (rom_ce) rom_inst <= romWord(rom_addr);

  // Transaction-level model: an access is busy from grant until ack seen at least two edges later
  logic        mBusy, mOwnerMem, mLastMem, mCe, mIfValid, mMemValid;
  logic [31:0] mAddr, mIfData, mMemData;
  int          mAge;
  int          waitLeft = 0;
  logic        reissue = 1'b0;

  task automatic modelReset();
    mBusy = 0; mOwnerMem = 0; mLastMem = 1; mCe = 0; mIfValid = 0; mMemValid = 0;
    mAddr = '0; mIfData = '0; mMemData = '0; mAge = 0;
  endtask

  task automatic modelEdge();
    mIfValid = 0;
    mMemValid = 0;
    if (!mBusy) begin
      if (if_req || mem_req) begin
`ifdef ROM_ARB_RR_EN
        mOwnerMem = mem_req && (!if_req || !mLastMem);
`else
        mOwnerMem = mem_req;
`endif
        mLastMem = mOwnerMem;
        mAddr = mOwnerMem ? mem_addr : if_addr;
        mBusy = 1; mAge = 0; mCe = 1;
      end
    end else begin
      mAge++;
      if (mAge >= 2 && rom_ack) begin
        if (mOwnerMem) begin mMemData = romWord(mAddr); mMemValid = 1; end
        else begin mIfData = romWord(mAddr); mIfValid = 1; end
        mBusy = 0; mCe = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("rom_ce", 32'(rom_ce), 32'(mCe));
    checkOutput("rom_addr", rom_addr, mAddr);
    checkOutput("if_valid", 32'(if_valid), 32'(mIfValid));
    checkOutput("mem_valid", 32'(mem_valid), 32'(mMemValid));
    checkOutput("if_rdata", if_rdata, mIfData);
    checkOutput("mem_rdata", mem_rdata, mMemData);
    checkOutput("stall_req", 32'(stall_req),
                32'((if_req & ~mIfValid) | (mem_req & ~mMemValid)));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic mr, input logic [31:0] ma);
    if_req = ir; if_addr = ia; mem_req = mr; mem_addr = ma;
  endtask

  // Requesters hold req until their valid, then drop it or re-issue at the next word
  task automatic serviceCycles(input int n);
    for (int i = 0; i < n; i++) begin
      rom_ack = !(mBusy && mAge >= 1 && waitLeft > 0);
      if (!rom_ack) waitLeft--;
      stepCycle();
      if (if_req && mIfValid) begin
        if (reissue) if_addr = if_addr + 32'd4; else if_req = 1'b0;
      end
      if (mem_req && mMemValid) begin
        if (reissue) mem_addr = mem_addr + 32'd4; else mem_req = 1'b0;
      end
    end
  endtask

  task automatic randomAgents();
    if (if_req) begin
      if (mIfValid) begin
        if ($urandom_range(0, 1) == 1) if_addr = 32'($urandom_range(0, 63)) << 2;
        else if_req = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      if_req = 1'b1; if_addr = 32'($urandom_range(0, 63)) << 2;
    end
    if (mem_req) begin
      if (mMemValid) begin
        if ($urandom_range(0, 1) == 1) mem_addr = 32'($urandom_range(0, 63)) << 2;
        else mem_req = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      mem_req = 1'b1; mem_addr = 32'($urandom_range(0, 63)) << 2;
    end
    rom_ack = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    rst = 1'b1;
    serviceCycles(2);

    // Single IF read at 0x4
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0);
    serviceCycles(6);

    // Simultaneous requests
    applyStimulus(1'b1, 32'h0, 1'b1, 32'h8);
    serviceCycles(10);

    // Two wait states in DATA
    waitLeft = 2;
    applyStimulus(1'b1, 32'h10, 1'b0, 32'h0);
    serviceCycles(8);

    // Back-to-back IF: re-issue at 0x8 in the valid cycle, then drop
    reissue = 1'b1;
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0);
    serviceCycles(4);
    reissue = 1'b0;
    serviceCycles(6);

    // Both requesters held continuously, then drained
    reissue = 1'b1;
    applyStimulus(1'b1, 32'h20, 1'b1, 32'h40);
    serviceCycles(12);
    reissue = 1'b0;
    serviceCycles(14);

    // Reset while the access sits in DATA
    applyStimulus(1'b1, 32'hC, 1'b0, 32'h0);
    serviceCycles(2);
    #2;
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    rst = 1'b1;
    serviceCycles(5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomAgents();
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
